// File: rtl/decoder_nto2n_scan.sv
// decoder_nto2n_scan
//   Registered N-to-2^N decoder with active-low outputs and an auto-scan mode.
//   Direct mode decodes sel. Scan mode walks one low output through indices
//   0..scan_last. Each index is held for dwell+1 cycles. BLANK_CYC all-high
//   cycles are inserted between steps so no two outputs overlap.
//
// Ports
//   clk, rst_n  clock, asynchronous active-low reset
//   en          active-high enable; en=0 forces all outputs high
//   mode        0 = direct decode, 1 = auto-scan
//   sel         direct-mode index
//   dwell       scan hold time minus one; sampled whenever the dwell counter loads
//   scan_last   last scan index; sampled at each step
//   y_n         decoded outputs, active low, registered
//   idx         index currently or last driven
//   active      high while one y_n bit is low
//   wrap        one-cycle pulse when a scan step returns to index 0

// One output lane: compares the next index against its own lane number.
module decoder_nto2n_scan_lane #(
  parameter int SEL_W = 3,
  parameter int LANE  = 0
) (
  input  logic [SEL_W-1:0] sel,
  input  logic             drv,
  output logic             y_n
);
  assign y_n = ~(drv && (sel == SEL_W'(LANE)));
endmodule

module decoder_nto2n_scan #(
  parameter int SEL_W     = 3,
  parameter int DWELL_W   = 8,
  parameter int BLANK_CYC = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic [DWELL_W-1:0]    dwell,
  input  logic [SEL_W-1:0]      scan_last,
  output logic [(1<<SEL_W)-1:0] y_n,
  output logic [SEL_W-1:0]      idx,
  output logic                  active,
  output logic                  wrap
);
  localparam int NOUT = 1 << SEL_W;
  localparam int BW   = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
  localparam logic [BW-1:0] BLOAD = BW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);

  typedef enum logic [1:0] {IDLE, DIRECT, SCAN_ON, SCAN_BLANK} state_t;

  state_t               state, state_d;
  logic [SEL_W-1:0]     idx_d;
  logic                 drv_d, wrap_d, do_step, last_hit;
  logic [DWELL_W-1:0]   dcnt, dcnt_d;
  logic [BW-1:0]        bcnt, bcnt_d;
  logic [NOUT-1:0]      y_n_d;

  // >= so that lowering scan_last below the current index wraps on the next step
  assign last_hit = (idx >= scan_last);

  always_comb begin
    state_d = state;
    idx_d   = idx;
    drv_d   = active;
    wrap_d  = 1'b0;
    dcnt_d  = dcnt;
    bcnt_d  = bcnt;
    do_step = 1'b0;
    if (!en) begin
      state_d = IDLE;
      drv_d   = 1'b0;
    end else if (!mode) begin
      state_d = DIRECT;
      idx_d   = sel;
      drv_d   = 1'b1;
    end else begin
      case (state)
        IDLE, DIRECT: begin
          // scan entry always restarts at index 0
          state_d = SCAN_ON;
          idx_d   = '0;
          drv_d   = 1'b1;
          dcnt_d  = dwell;
        end
        SCAN_ON: begin
          if (dcnt != '0) begin
            dcnt_d = dcnt - DWELL_W'(1);
          end else if (BLANK_CYC > 0) begin
            state_d = SCAN_BLANK;
            drv_d   = 1'b0;
            bcnt_d  = BLOAD;
          end else begin
            do_step = 1'b1;
          end
        end
        SCAN_BLANK: begin
          if (bcnt != '0) bcnt_d = bcnt - BW'(1);
          else            do_step = 1'b1;
        end
        default: begin
          state_d = IDLE;
          drv_d   = 1'b0;
        end
      endcase
      if (do_step) begin
        state_d = SCAN_ON;
        idx_d   = last_hit ? '0 : idx + SEL_W'(1);
        wrap_d  = last_hit;
        drv_d   = 1'b1;
        dcnt_d  = dwell;
      end
    end
  end

  // Outputs are decoded from a single index, so at most one bit can be low.
  for (genvar g = 0; g < NOUT; g++) begin : g_lane
    decoder_nto2n_scan_lane #(.SEL_W(SEL_W), .LANE(g)) u_lane (
      .sel (idx_d),
      .drv (drv_d),
      .y_n (y_n_d[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      y_n    <= '1;
      idx    <= '0;
      active <= 1'b0;
      wrap   <= 1'b0;
      dcnt   <= '0;
      bcnt   <= '0;
    end else begin
      state  <= state_d;
      y_n    <= y_n_d;
      idx    <= idx_d;
      active <= drv_d;
      wrap   <= wrap_d;
      dcnt   <= dcnt_d;
      bcnt   <= bcnt_d;
    end
  end
endmodule

// File: tb/tb_decoder_nto2n_scan.sv
// Scoreboard bench for decoder_nto2n_scan. Three instances share stimulus:
//   a: defaults (SEL_W=3, BLANK_CYC=1)
//   b: SEL_W=3, BLANK_CYC=0
//   c: SEL_W=4, BLANK_CYC=0
// The stimulus queues the expected outputs for a target cycle. A monitor
// compares them on the falling edge of that cycle.
module tb_decoder_nto2n_scan;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0, mode = 1'b0;
  logic [3:0] sel = '0, scan_last = '0;
  logic [7:0] dwell = '0;

  logic [7:0]  ya, yb;
  logic [15:0] yc;
  logic [2:0]  ia, ib;
  logic [3:0]  ic;
  logic        aca, acb, acc, wa, wb, wc;

  decoder_nto2n_scan u_a (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel[2:0]), .dwell(dwell),
    .scan_last(scan_last[2:0]), .y_n(ya), .idx(ia), .active(aca), .wrap(wa));
  decoder_nto2n_scan #(.SEL_W(3), .DWELL_W(8), .BLANK_CYC(0)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel[2:0]), .dwell(dwell),
    .scan_last(scan_last[2:0]), .y_n(yb), .idx(ib), .active(acb), .wrap(wb));
  decoder_nto2n_scan #(.SEL_W(4), .DWELL_W(8), .BLANK_CYC(0)) u_c (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .dwell(dwell),
    .scan_last(scan_last), .y_n(yc), .idx(ic), .active(acc), .wrap(wc));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    int          dut;
    logic [15:0] y;
    logic [3:0]  idx;
    bit          ci;
    bit          w;
    string       nm;
  } exp_t;

  exp_t q[$];
  int ntests = 0, nfail = 0;

  task automatic compare(input exp_t e);
    logic [15:0] ay, ones;
    logic [3:0]  ai;
    logic        aa, aw, ea;
    case (e.dut)
      0:       begin ay = {8'h00, ya}; ai = {1'b0, ia}; aa = aca; aw = wa; end
      1:       begin ay = {8'h00, yb}; ai = {1'b0, ib}; aa = acb; aw = wb; end
      default: begin ay = yc;          ai = ic;         aa = acc; aw = wc; end
    endcase
    ones = (e.dut == 2) ? 16'hFFFF : 16'h00FF;
    ea = (e.y != ones);
    ntests++;
    if (ay !== e.y || aa !== ea || aw !== e.w || (e.ci && ai !== e.idx)) begin
      nfail++;
      $display("FAIL %s (dut%0d cyc %0d): got y_n=%h idx=%0d active=%b wrap=%b, want y_n=%h idx=%0d active=%b wrap=%b",
               e.nm, e.dut, cyc, ay, ai, aa, aw, e.y, e.idx, ea, e.w);
    end
  endtask

  // Queue an expectation for the cycle after the coming edge, then wait for it.
  task automatic ex(input int dut, input logic [15:0] y, input logic [3:0] i,
                    input bit ci, input bit w, input string nm);
    exp_t e;
    e.cyc = cyc + 1; e.dut = dut; e.y = y; e.idx = i; e.ci = ci; e.w = w; e.nm = nm;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic now_chk(input int dut, input logic [15:0] y, input logic [3:0] i,
                         input bit w, input string nm);
    exp_t e;
    e.cyc = cyc; e.dut = dut; e.y = y; e.idx = i; e.ci = 1'b1; e.w = w; e.nm = nm;
    compare(e);
  endtask

  // monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        if (e.cyc < cyc) begin
          ntests++; nfail++;
          $display("FAIL %s: expectation for cyc %0d missed (now %0d)", e.nm, e.cyc, cyc);
        end else begin
          compare(e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  logic [7:0]  dtab [8]  = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
  logic [7:0]  stab [17] = '{8'hFE, 8'hFE, 8'hFE, 8'hFF, 8'hFD, 8'hFD, 8'hFD, 8'hFF,
                            8'hFB, 8'hFB, 8'hFB, 8'hFF, 8'hF7, 8'hF7, 8'hF7, 8'hFF, 8'hFE};

  initial begin
    logic [15:0] one16;
    one16 = 16'h0001;
    repeat (2) @(negedge clk);
    now_chk(0, 16'h00FF, 0, 0, "reset_a");
    now_chk(1, 16'h00FF, 0, 0, "reset_b");
    now_chk(2, 16'hFFFF, 0, 0, "reset_c");

    // async reset mid-cycle while decoding sel=5
    rst_n = 1'b1; en = 1'b1; mode = 1'b0; sel = 4'd5;
    ex(0, 16'h00DF, 5, 1, 0, "pre_reset");
    ex(0, 16'h00DF, 5, 1, 0, "pre_reset_hold");
    @(posedge clk); #2 rst_n = 1'b0;
    #1 now_chk(0, 16'h00FF, 0, 0, "async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    ex(0, 16'h00DF, 5, 1, 0, "reset_release");

    // direct sweep
    for (int s = 0; s < 8; s++) begin
      sel = 4'(s);
      ex(0, {8'h00, dtab[s]}, 4'(s), 1, 0, "direct");
    end
    en = 1'b0;
    ex(0, 16'h00FF, 7, 1, 0, "direct_en0");

    // scan dwell=2 scan_last=3 with one blank cycle
    en = 1'b1; mode = 1'b1; dwell = 8'd2; scan_last = 4'd3;
    for (int i = 0; i < 17; i++)
      ex(0, {8'h00, stab[i]}, 4'((i / 4) % 4), 1, (i == 16), "scan_d2");
    en = 1'b0;
    ex(0, 16'h00FF, 0, 1, 0, "scan_en0");

    // no blanking, single index: FE forever, wrap every cycle after entry
    en = 1'b1; mode = 1'b1; dwell = 8'd0; scan_last = 4'd0;
    ex(1, 16'h00FE, 0, 1, 0, "scan_l0_entry");
    repeat (5) ex(1, 16'h00FE, 0, 1, 1, "scan_l0_wrap");
    en = 1'b0;
    ex(1, 16'h00FF, 0, 1, 0, "scan_l0_off");

    // retarget: dwell=1 gives 2 on + 1 blank per index
    en = 1'b1; mode = 1'b1; dwell = 8'd1; scan_last = 4'd7;
    for (int r = 1; r <= 18; r++) begin
      if ((r - 1) % 3 == 2) ex(0, 16'h00FF, 4'((r - 1) / 3), 1, 0, "retgt_blank");
      else                  ex(0, {8'h00, dtab[(r - 1) / 3]}, 4'((r - 1) / 3), 1, 0, "retgt_on");
    end
    scan_last = 4'd2;   // idx is 5, now in blank
    ex(0, 16'h00FE, 0, 1, 1, "retgt_wrap");
    ex(0, 16'h00FE, 0, 1, 0, "retgt_hold");
    ex(0, 16'h00FF, 0, 1, 0, "retgt_blank2");
    mode = 1'b0; sel = 4'd6;
    ex(0, 16'h00BF, 6, 1, 0, "blank_to_direct");

    // 16-output walking zero, no blanking
    en = 1'b0;
    ex(2, 16'hFFFF, 6, 1, 0, "c_off");
    en = 1'b1; mode = 1'b1; dwell = 8'd0; scan_last = 4'd15;
    for (int r = 1; r <= 34; r++) begin
      int i;
      i = (r - 1) % 16;
      ex(2, ~(one16 << i), 4'(i), 1, (r > 1 && i == 0), "walk16");
    end

    repeat (2) @(negedge clk);
    if (q.size() != 0) begin
      ntests++; nfail++;
      $display("FAIL drain: %0d expectations never checked", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
